// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control: Moore FSM sequencing fetch/decode/execute/memory/write-back
// and driving ALU operation, datapath selects and write enables.
module mips_multicycle_ctrl (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       aluZero_i,
    output logic [2:0] ALUop_o,
    output logic       aluSrcA_o,
    output logic [1:0] aluSrcB_o,
    output logic [1:0] pcSrc_o,
    output logic       pcEn_o,
    output logic       iorD_o,
    output logic       memWrite_o,
    output logic       irWrite_o,
    output logic       regWrite_o,
    output logic       regDst_o,
    output logic       memToReg_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_BEQEX  = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JEX    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q, state_d;
    logic   pc_write, branch;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_RST;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        ALUop_o    = ALU_ADD;
        aluSrcA_o  = 1'b0;
        aluSrcB_o  = 2'b00;
        pcSrc_o    = 2'b00;
        iorD_o     = 1'b0;
        memWrite_o = 1'b0;
        irWrite_o  = 1'b0;
        regWrite_o = 1'b0;
        regDst_o   = 1'b0;
        memToReg_o = 1'b0;
        illegal_o  = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state_q)
            S_FETCH: begin
                irWrite_o = 1'b1;
                aluSrcB_o = 2'b01;
                pc_write  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                aluSrcB_o = 2'b11;
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REXEC;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        illegal_o = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA_o = 1'b1;
                aluSrcB_o = 2'b10;
                state_d   = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iorD_o  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memToReg_o = 1'b1;
                regWrite_o = 1'b1;
            end
            S_MEMWR: begin
                iorD_o     = 1'b1;
                memWrite_o = 1'b1;
            end
            S_REXEC: begin
                aluSrcA_o = 1'b1;
                state_d   = S_RWB;
                case (funct_i)
                    6'b100000: ALUop_o = ALU_ADD;
                    6'b100010: ALUop_o = ALU_SUB;
                    6'b100100: ALUop_o = ALU_AND;
                    6'b100101: ALUop_o = ALU_OR;
                    6'b101010: ALUop_o = ALU_SLT;
                    default: begin
                        illegal_o = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_RWB: begin
                regDst_o   = 1'b1;
                regWrite_o = 1'b1;
            end
            S_BEQEX: begin
                aluSrcA_o = 1'b1;
                ALUop_o   = ALU_SUB;
                branch    = 1'b1;
                pcSrc_o   = 2'b01;
            end
            S_ADDIEX: begin
                aluSrcA_o = 1'b1;
                aluSrcB_o = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: regWrite_o = 1'b1;
            S_JEX: begin
                pcSrc_o  = 2'b10;
                pc_write = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pcEn_o  = pc_write | (branch & aluZero_i);
    assign state_o = state_q;

endmodule
